sdram_arbiter: RTL
==================

# sdram_arbiter

Shares the single 16-bit SDRAM port between the SPI flash emulator (read-only, latency-critical), the host image loader (read/write), and periodic refresh. Sits between `spi_flash`, the host loader and the SDRAM controller. Honours the flash's `spi_critical` / `ram_refresh_inhibit` locks while tracking and bounding owed refresh cycles.

## Interface
Parameters:
- `REFRESH_PERIOD`, 750: clock cycles between refresh credits.
- `REFRESH_MAX_PENDING`, 8: owed-refresh threshold for starvation handling (1..15).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `spi_critical`  in  1  flash holds bus lock; blocks new host/refresh grants.
- `ram_refresh_inhibit`  in  1  flash forbids starting refresh.
- `spi_addr`  in  32  flash read address (16-bit word in bits [23:1], bit 0 ignored).
- `spi_read_enable`  in  1  flash read request, level.
- `spi_read_data`  out  16  flash read data, valid with `spi_read_valid`.
- `spi_read_valid`  out  1  one-cycle completion pulse.
- `host_addr`  in  32  host word address (same mapping as `spi_addr`).
- `host_req`  in  1  host request, level, held until `host_ack`.
- `host_we`  in  1  1 = write, 0 = read; sampled at grant.
- `host_wdata`  in  16  write data; sampled at grant.
- `host_rdata`  out  16  read data, valid with `host_ack`.
- `host_ack`  out  1  one-cycle completion pulse (reads and writes).
- `sd_addr`  out  32  controller address.
- `sd_we`  out  1  controller write strobe qualifier.
- `sd_wdata`  out  16  controller write data.
- `sd_enable`  out  1  access request, held until `sd_done`.
- `sd_rdata`  in  16  controller read data, valid with `sd_done`.
- `sd_done`  in  1  access complete pulse.
- `sd_refresh`  out  1  refresh request, held until `sd_refresh_done`.
- `sd_refresh_done`  in  1  refresh complete pulse.
- `refresh_owed`  out  4  outstanding refresh credits.
- `errors`  out  8  sticky error flags.

## Operation
- States: IDLE, SPI, HOST, REFRESH. All outputs registered.
- Refresh timer: counts 0..REFRESH_PERIOD-1 continuously. At wrap, `refresh_owed` +1, saturating at 15; an increment attempted at 15 sets `errors[0]`. A timer increment and a refresh completion in the same cycle leave `refresh_owed` unchanged.
- IDLE grant priority, evaluated each cycle:
  1. `spi_read_enable`: go to SPI.
  2. `refresh_owed`≠0, `!ram_refresh_inhibit` and `!spi_critical`: go to REFRESH.
  3. `host_req` and `!spi_critical`: go to HOST.
- Holdoff: in the cycle `spi_read_valid` or `host_ack` is high, IDLE must not grant that same requester. This prevents re-issue from a stale level request.
- SPI: `sd_addr`←`spi_addr`, `sd_we`=0, `sd_enable`=1 until `sd_done`. Then latch `sd_rdata`, pulse `spi_read_valid`, return to IDLE.
- HOST: latch address, `host_we` and `host_wdata`; drive `sd_enable` until `sd_done`. Then pulse `host_ack` (with `host_rdata`=`sd_rdata` on reads) and return to IDLE. `host_req` low before `sd_done` sets `errors[1]`; the access still completes and is acked.
- REFRESH: `sd_refresh`=1 until `sd_refresh_done`. Then `refresh_owed` −1 and return to IDLE.
- In-flight accesses are never aborted. `spi_critical` rising mid-HOST or mid-REFRESH only delays the flash request until that access completes.
- `sd_done` outside SPI/HOST, or `sd_refresh_done` outside REFRESH, sets `errors[2]` and is otherwise ignored.
- `refresh_owed` ≥ REFRESH_MAX_PENDING sets `errors[3]`.
- `errors[7:4]` reserved, always 0.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, timer 0, `refresh_owed`=0, `errors`=0. All outputs 0, data outputs included.
- Grant latency: request seen in IDLE at cycle n; `sd_enable` or `sd_refresh` high at n+1.
- Completion: `sd_done` at cycle m; `spi_read_valid` or `host_ack` high at m+1 only, state IDLE at m+1. Next grant earliest at m+2, so `sd_enable` is low for at least one cycle between accesses.
- Minimum flash round trip: 2 cycles plus controller latency.
- Reset asserted mid-access drops `sd_enable` and `sd_refresh` immediately. Partially owed work is discarded.

## Configuration
- `SDRAM_ARB_FORCE_REFRESH_EN` defined: with `refresh_owed` ≥ REFRESH_MAX_PENDING in IDLE, REFRESH is granted above every other priority, ignoring `spi_critical`, `ram_refresh_inhibit` and `spi_read_enable`. `errors[3]` still sets.
- Undefined: refresh is never forced. Priority is exactly as listed in Operation.

## Test plan
- Reset, idle for 3×REFRESH_PERIOD with no locks -> three refreshes issued, `refresh_owed` returns to 0, `errors`=0.
- `spi_read_enable` with `spi_addr`=0x000123, controller returns 0xBEEF after 4 cycles -> `sd_enable` at n+1, one `spi_read_valid` pulse with 0xBEEF, no second issue.
- `host_req` write and `spi_read_enable` asserted in the same cycle -> SPI granted first, HOST next; `host_ack` a single pulse.
- `ram_refresh_inhibit`=1 for 10×REFRESH_PERIOD, REFRESH_MAX_PENDING=8 -> `refresh_owed`=10, `errors[3]`=1. With `SDRAM_ARB_FORCE_REFRESH_EN` defined: refresh is forced at owed=8 and `refresh_owed` never exceeds 8.
- `spi_critical`=1 with `host_req` pending for 100 cycles -> no host grant; host granted one cycle after `spi_critical` drops.
- Reset pulsed mid-HOST read -> all outputs 0 immediately, no `host_ack`. A later `sd_done` pulse sets `errors[2]`.

Source files
------------

// File: rtl/sdram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sdram_arbiter                                              |
// | Description : Shares one 16-bit SDRAM controller port between the SPI     |
// |               flash emulator (read-only), the host image loader (r/w)    |
// |               and periodic refresh, tracking owed refresh credits.       |
// | Options     : `define SDRAM_ARB_FORCE_REFRESH_EN to force refresh above   |
// |               every other requester once the owed count reaches          |
// |               REFRESH_MAX_PENDING.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sdram_arbiter #(
  parameter int REFRESH_PERIOD      = 750,
  parameter int REFRESH_MAX_PENDING = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_critical,
  input  logic        ram_refresh_inhibit,
  input  logic [31:0] spi_addr,
  input  logic        spi_read_enable,
  output logic [15:0] spi_read_data,
  output logic        spi_read_valid,
  input  logic [31:0] host_addr,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_ack,
  output logic [31:0] sd_addr,
  output logic        sd_we,
  output logic [15:0] sd_wdata,
  output logic        sd_enable,
  input  logic [15:0] sd_rdata,
  input  logic        sd_done,
  output logic        sd_refresh,
  input  logic        sd_refresh_done,
  output logic [3:0]  refresh_owed,
  output logic [7:0]  errors
);

  localparam int              c_TW         = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(REFRESH_PERIOD - 1);
  localparam logic [3:0]      c_MAX_PEND   = 4'(REFRESH_MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPI     = 2'd1,
    ST_HOST    = 2'd2,
    ST_REFRESH = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_TW-1:0] r_timer;
  logic [3:0]      r_owed;
  logic [3:0]      r_err;
  logic [15:0]     r_spi_rdata;
  logic            r_spi_valid;
  logic [15:0]     r_host_rdata;
  logic            r_host_ack;
  logic [31:0]     r_sd_addr;
  logic            r_sd_we;
  logic [15:0]     r_sd_wdata;
  logic            r_sd_enable;
  logic            r_sd_refresh;

  // The controller works in 16-bit words: drop the byte-lane bit and the
  // top byte of the incoming byte addresses.
  logic [31:0] w_spi_word;
  logic [31:0] w_host_word;
  logic        w_unused_addr;
  assign w_spi_word    = {9'd0, spi_addr[23:1]};
  assign w_host_word   = {9'd0, host_addr[23:1]};
  assign w_unused_addr = &{1'b0, spi_addr[31:24], spi_addr[0], host_addr[31:24], host_addr[0]};

  // A requester whose completion pulse is showing this cycle still has its
  // stale level request up; masking it avoids an immediate re-issue.
  logic w_spi_req;
  logic w_host_req;
  logic w_ref_ok;
  logic w_force_ref;
  logic w_tick;
  logic w_ref_done;
  logic w_in_access;
  assign w_spi_req   = spi_read_enable & ~r_spi_valid;
  assign w_host_req  = host_req & ~r_host_ack & ~spi_critical;
  assign w_ref_ok    = (r_owed != 4'd0) & ~ram_refresh_inhibit & ~spi_critical;
`ifdef SDRAM_ARB_FORCE_REFRESH_EN
  assign w_force_ref = (r_owed >= c_MAX_PEND);
`else
  assign w_force_ref = 1'b0;
`endif
  assign w_tick      = (r_timer == c_TIMER_LAST);
  assign w_ref_done  = (r_state == ST_REFRESH) & sd_refresh_done;
  assign w_in_access = (r_state == ST_SPI) | (r_state == ST_HOST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: grant priority in IDLE, otherwise wait for the completion pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_force_ref)     w_state_nxt = ST_REFRESH;
        else if (w_spi_req)  w_state_nxt = ST_SPI;
        else if (w_ref_ok)   w_state_nxt = ST_REFRESH;
        else if (w_host_req) w_state_nxt = ST_HOST;
      end
      ST_SPI, ST_HOST: begin
        if (sd_done) w_state_nxt = ST_IDLE;
      end
      ST_REFRESH: begin
        if (sd_refresh_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered controller-side outputs: strobes follow the next state,
  // address/data are captured at the grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sd_enable  <= 1'b0;
      r_sd_refresh <= 1'b0;
      r_sd_addr    <= 32'd0;
      r_sd_we      <= 1'b0;
      r_sd_wdata   <= 16'd0;
    end else begin
      r_sd_enable  <= (w_state_nxt == ST_SPI) | (w_state_nxt == ST_HOST);
      r_sd_refresh <= (w_state_nxt == ST_REFRESH);
      if (r_state == ST_IDLE && w_state_nxt == ST_SPI) begin
        r_sd_addr <= w_spi_word;
        r_sd_we   <= 1'b0;
      end else if (r_state == ST_IDLE && w_state_nxt == ST_HOST) begin
        r_sd_addr  <= w_host_word;
        r_sd_we    <= host_we;
        r_sd_wdata <= host_wdata;
      end
    end
  end

  // Completion pulses and returned read data toward flash and host.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_spi_valid  <= 1'b0;
      r_spi_rdata  <= 16'd0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= 16'd0;
    end else begin
      r_spi_valid <= (r_state == ST_SPI) & sd_done;
      r_host_ack  <= (r_state == ST_HOST) & sd_done;
      if (r_state == ST_SPI && sd_done) begin
        r_spi_rdata <= sd_rdata;
      end
      if (r_state == ST_HOST && sd_done && !r_sd_we) begin
        r_host_rdata <= sd_rdata;
      end
    end
  end

  // Refresh timer and owed-credit counter; a credit and a completion in the
  // same cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
      r_owed  <= 4'd0;
    end else begin
      r_timer <= w_tick ? '0 : r_timer + 1'b1;
      case ({w_tick, w_ref_done})
        2'b10:   if (r_owed != 4'hF) r_owed <= r_owed + 4'd1;
        2'b01:   r_owed <= r_owed - 4'd1;
        default: r_owed <= r_owed;
      endcase
    end
  end

  // Sticky error flags: [0] owed overflow, [1] host dropped request early,
  // [2] stray controller completion, [3] owed reached the pending threshold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 4'd0;
    end else begin
      r_err[0] <= r_err[0] | (w_tick & ~w_ref_done & (r_owed == 4'hF));
      r_err[1] <= r_err[1] | ((r_state == ST_HOST) & ~host_req & ~sd_done);
      r_err[2] <= r_err[2] | (sd_done & ~w_in_access)
                           | (sd_refresh_done & (r_state != ST_REFRESH));
      r_err[3] <= r_err[3] | (r_owed >= c_MAX_PEND);
    end
  end

  assign spi_read_data  = r_spi_rdata;
  assign spi_read_valid = r_spi_valid;
  assign host_rdata     = r_host_rdata;
  assign host_ack       = r_host_ack;
  assign sd_addr        = r_sd_addr;
  assign sd_we          = r_sd_we;
  assign sd_wdata       = r_sd_wdata;
  assign sd_enable      = r_sd_enable;
  assign sd_refresh     = r_sd_refresh;
  assign refresh_owed   = r_owed;
  assign errors         = {4'd0, r_err};

endmodule
`default_nettype wire
